// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_arbiter
//  Purpose  : Two-requester round-robin front end for a single sqrt /
//             inverse-sqrt core. Grants one requester at a time, issues its
//             operands to the core, waits for the result with a bounded
//             timeout (flushing the core on expiry) and returns a one-cycle
//             response pulse to the granted requester.
//  Ports    : clk, rst (sync, active-low)
//             reqN_valid_i/s_i/odd_i/inv_i/spec_i -> reqN_ready_o   (N=0,1)
//             respN_valid_o/res_o/err_o                             (N=0,1)
//             core_do_o/s_o/odd_o/inv_o/spec_o/rst_o -> core
//             core_valid_i/res_i <- core
//  Revision : 1.0  initial release
// ============================================================================
module sqrt_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    // Significand width: 1 + LAMP_FLOAT_F_DW of the lampFPU configuration.
    parameter int SIG_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid_i,
    input  logic [SIG_W-1:0] req0_s_i,
    input  logic             req0_odd_i,
    input  logic             req0_inv_i,
    input  logic             req0_spec_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [SIG_W-1:0] req1_s_i,
    input  logic             req1_odd_i,
    input  logic             req1_inv_i,
    input  logic             req1_spec_i,
    output logic             req1_ready_o,
    output logic             resp0_valid_o,
    output logic [SIG_W-1:0] resp0_res_o,
    output logic             resp0_err_o,
    output logic             resp1_valid_o,
    output logic [SIG_W-1:0] resp1_res_o,
    output logic             resp1_err_o,
    output logic             core_do_o,
    output logic [SIG_W-1:0] core_s_o,
    output logic             core_odd_o,
    output logic             core_inv_o,
    output logic             core_spec_o,
    output logic             core_rst_o,
    input  logic             core_valid_i,
    input  logic [SIG_W-1:0] core_res_i
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_ptr;
    logic             r_gnt;
    logic [SIG_W-1:0] r_s;
    logic             r_odd;
    logic             r_inv;
    logic             r_spec;
    logic [CNT_W-1:0] r_cnt;
    logic [SIG_W-1:0] r_res0;
    logic [SIG_W-1:0] r_res1;
    logic             r_err0;
    logic             r_err1;

    logic             w_any;
    logic             w_gnt;
    logic             w_cnt_last;
    logic             w_timeout;
    logic             w_hold;

    assign w_any      = req0_valid_i | req1_valid_i;
    // Pointer only matters on contention; a lone requester always wins.
    assign w_gnt      = (req0_valid_i & req1_valid_i) ? r_ptr : req1_valid_i;
    assign w_cnt_last = (r_cnt >= c_CNT_LAST);
    // A result arriving on the last allowed cycle takes precedence over abort.
    assign w_timeout  = (r_state == c_ST_WAIT) && !core_valid_i && w_cnt_last;
    assign w_hold     = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (core_valid_i || w_cnt_last) w_state_nxt = c_ST_RESP;
            c_ST_RESP:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, timeout counter, response registers, RR pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr  <= 1'b0;
            r_gnt  <= 1'b0;
            r_s    <= '0;
            r_odd  <= 1'b0;
            r_inv  <= 1'b0;
            r_spec <= 1'b0;
            r_cnt  <= '0;
            r_res0 <= '0;
            r_res1 <= '0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_gnt;
                        r_s    <= w_gnt ? req1_s_i    : req0_s_i;
                        r_odd  <= w_gnt ? req1_odd_i  : req0_odd_i;
                        r_inv  <= w_gnt ? req1_inv_i  : req0_inv_i;
                        r_spec <= w_gnt ? req1_spec_i : req0_spec_i;
                    end
                end
                c_ST_ISSUE: begin
                    r_cnt <= '0;
                end
                c_ST_WAIT: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (core_valid_i) begin
                        if (r_gnt) begin
                            r_res1 <= core_res_i;
                            r_err1 <= 1'b0;
                        end else begin
                            r_res0 <= core_res_i;
                            r_err0 <= 1'b0;
                        end
                    end else if (w_cnt_last) begin
                        if (r_gnt) begin
                            r_res1 <= '0;
                            r_err1 <= 1'b1;
                        end else begin
                            r_res0 <= '0;
                            r_err0 <= 1'b1;
                        end
                    end
                end
                c_ST_RESP: begin
                    // Next contention goes to whoever was not just served.
                    r_ptr <= ~r_gnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic; everything is forced quiet while reset is held, except
    // the core flush which is held asserted.
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        resp0_valid_o = 1'b0;
        resp1_valid_o = 1'b0;
        core_do_o     = 1'b0;
        core_spec_o   = 1'b0;
        core_s_o      = '0;
        core_odd_o    = 1'b0;
        core_inv_o    = 1'b0;
        core_rst_o    = !rst || w_timeout;
        if (rst) begin
            req0_ready_o  = (r_state == c_ST_IDLE) && w_any && !w_gnt;
            req1_ready_o  = (r_state == c_ST_IDLE) && w_any &&  w_gnt;
            resp0_valid_o = (r_state == c_ST_RESP) && !r_gnt;
            resp1_valid_o = (r_state == c_ST_RESP) &&  r_gnt;
            core_do_o     = (r_state == c_ST_ISSUE) && !r_spec;
            core_spec_o   = (r_state == c_ST_ISSUE) &&  r_spec;
            if (w_hold) begin
                core_s_o   = r_s;
                core_odd_o = r_odd;
                core_inv_o = r_inv;
            end
        end
    end

    assign resp0_res_o = r_res0;
    assign resp0_err_o = r_err0;
    assign resp1_res_o = r_res1;
    assign resp1_err_o = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_arbiter
//  Purpose  : Self-checking bench for sqrt_arbiter with a behavioural sqrt
//             core of configurable latency and a round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_arbiter;

    localparam int TMO = 64;
    localparam int W   = 8;

    typedef struct { logic [W-1:0] s; logic odd; logic inv; logic spec; } op_t;
    typedef struct { int port; logic [W-1:0] res; logic err; int cyc; } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         req0_valid_i = 1'b0, req0_odd_i = 1'b0, req0_inv_i = 1'b0, req0_spec_i = 1'b0;
    logic [W-1:0] req0_s_i = '0;
    logic         req1_valid_i = 1'b0, req1_odd_i = 1'b0, req1_inv_i = 1'b0, req1_spec_i = 1'b0;
    logic [W-1:0] req1_s_i = '0;
    logic         req0_ready_o, req1_ready_o;
    logic         resp0_valid_o, resp0_err_o, resp1_valid_o, resp1_err_o;
    logic [W-1:0] resp0_res_o, resp1_res_o;
    logic         core_do_o, core_odd_o, core_inv_o, core_spec_o, core_rst_o;
    logic [W-1:0] core_s_o;
    logic         core_valid_i;
    logic [W-1:0] core_res_i;

    sqrt_arbiter #(.TIMEOUT_CYCLES(TMO), .SIG_W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid_i), .req0_s_i(req0_s_i), .req0_odd_i(req0_odd_i),
        .req0_inv_i(req0_inv_i), .req0_spec_i(req0_spec_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_s_i(req1_s_i), .req1_odd_i(req1_odd_i),
        .req1_inv_i(req1_inv_i), .req1_spec_i(req1_spec_i), .req1_ready_o(req1_ready_o),
        .resp0_valid_o(resp0_valid_o), .resp0_res_o(resp0_res_o), .resp0_err_o(resp0_err_o),
        .resp1_valid_o(resp1_valid_o), .resp1_res_o(resp1_res_o), .resp1_err_o(resp1_err_o),
        .core_do_o(core_do_o), .core_s_o(core_s_o), .core_odd_o(core_odd_o),
        .core_inv_o(core_inv_o), .core_spec_o(core_spec_o), .core_rst_o(core_rst_o),
        .core_valid_i(core_valid_i), .core_res_i(core_res_i)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural core: what the sqrt core would compute for an operand set.
    function automatic logic [W-1:0] core_fn(input op_t o);
        logic [W-1:0] mask;
        mask = {o.odd, o.inv, {(W-2){1'b0}}};
        return o.spec ? ~o.s : (o.s ^ mask);
    endfunction

    function automatic op_t rand_op(input bit allow_spec);
        op_t o;
        o.s    = W'($urandom);
        o.odd  = 1'($urandom);
        o.inv  = 1'($urandom);
        o.spec = allow_spec && ($urandom_range(0, 3) == 0);
        return o;
    endfunction

    // ---------------- core model (drives at +1) ----------------
    logic         mdl_valid = 1'b0, man_valid = 1'b0;
    logic [W-1:0] mdl_res = '0, man_res = '0;
    int           mdl_cnt = 0, mdl_lat = 5;
    bit           mdl_mute = 1'b0, mdl_rand = 1'b0;
    op_t          mdl_op;

    assign core_valid_i = mdl_valid | man_valid;
    assign core_res_i   = mdl_valid ? mdl_res : man_res;

    always @(posedge clk) begin
        #1;
        mdl_valid = 1'b0;
        if (!rst) begin
            mdl_cnt = 0;
        end else begin
            if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) mdl_valid = 1'b1;
            end
            if ((core_do_o || core_spec_o) && !mdl_mute) begin
                mdl_op.s = core_s_o; mdl_op.odd = core_odd_o;
                mdl_op.inv = core_inv_o; mdl_op.spec = core_spec_o;
                mdl_res = core_fn(mdl_op);
                mdl_cnt = mdl_rand ? int'($urandom_range(1, 12)) : mdl_lat;
            end
        end
    end

    // ---------------- monitor (samples at +2) ----------------
    int    cyc = 0, do_cnt = 0, spec_cnt = 0, crst_cnt = 0;
    int    do_cyc = 0, spec_cyc = 0, crst_cyc = 0, ready_cyc = 0;
    resp_t resp_q[$];
    op_t   iss_log[$];
    int    gnt_log[$];
    resp_t mon_r;
    op_t   mon_o;

    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (core_do_o || core_spec_o) begin
            mon_o.s = core_s_o; mon_o.odd = core_odd_o;
            mon_o.inv = core_inv_o; mon_o.spec = core_spec_o;
            iss_log.push_back(mon_o);
        end
        if (core_do_o)   begin do_cnt++;   do_cyc = cyc;   end
        if (core_spec_o) begin spec_cnt++; spec_cyc = cyc; end
        if (core_rst_o && rst) begin crst_cnt++; crst_cyc = cyc; end
        if (resp0_valid_o) begin
            mon_r.port = 0; mon_r.res = resp0_res_o; mon_r.err = resp0_err_o; mon_r.cyc = cyc;
            resp_q.push_back(mon_r);
        end
        if (resp1_valid_o) begin
            mon_r.port = 1; mon_r.res = resp1_res_o; mon_r.err = resp1_err_o; mon_r.cyc = cyc;
            resp_q.push_back(mon_r);
        end
    end

    function automatic resp_t get_resp(input int i);
        resp_t r;
        r.port = -1; r.res = 'x; r.err = 1'bx; r.cyc = -1;
        if (i >= 0 && i < resp_q.size()) r = resp_q[i];
        return r;
    endfunction

    function automatic int get_gnt(input int i);
        return (i >= 0 && i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    // ---------------- requester driver ----------------
    op_t q0[$], q1[$];

    // Drive queue heads at +3, record acceptance at +4 once ready has settled.
    task automatic step();
        @(posedge clk);
        #3;
        req0_valid_i = (q0.size() > 0);
        if (q0.size() > 0) begin
            req0_s_i = q0[0].s; req0_odd_i = q0[0].odd; req0_inv_i = q0[0].inv; req0_spec_i = q0[0].spec;
        end
        req1_valid_i = (q1.size() > 0);
        if (q1.size() > 0) begin
            req1_s_i = q1[0].s; req1_odd_i = q1[0].odd; req1_inv_i = q1[0].inv; req1_spec_i = q1[0].spec;
        end
        #1;
        if (req0_ready_o) begin
            gnt_log.push_back(0); ready_cyc = cyc;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (req1_ready_o) begin
            gnt_log.push_back(1); ready_cyc = cyc;
            if (q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    task automatic run_until(input int nresp, input int budget, output bit ok);
        int n;
        n = 0;
        while ((resp_q.size() < nresp || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        ok = (resp_q.size() >= nresp) && (q0.size() == 0) && (q1.size() == 0);
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        mdl_mute = 1'b0; mdl_rand = 1'b0; man_valid = 1'b0;
        resp_q.delete(); iss_log.delete(); gnt_log.delete();
    endtask

    // ---------------- reference round-robin model ----------------
    op_t   e0[$], e1[$];
    resp_t exp_q[$];
    op_t   exp_iss[$];
    int    ref_ptr = 0;

    // Serve all pending ops: on contention the pointer owner wins, then the
    // pointer goes to the requester that was not served.
    task automatic ref_arbitrate();
        int    w;
        op_t   o;
        resp_t r;
        exp_q.delete(); exp_iss.delete();
        while (e0.size() > 0 || e1.size() > 0) begin
            if (e0.size() > 0 && e1.size() > 0) w = ref_ptr;
            else w = (e0.size() > 0) ? 0 : 1;
            o = (w == 1) ? e1.pop_front() : e0.pop_front();
            r.port = w; r.res = core_fn(o); r.err = 1'b0; r.cyc = 0;
            exp_q.push_back(r);
            exp_iss.push_back(o);
            ref_ptr = 1 - w;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        op_t a;
        a.s = 8'hA5; a.odd = 1'b1; a.inv = 1'b1; a.spec = 1'b0;
        q0.push_back(a); q1.push_back(a);
        rst = 1'b0;
        step(); step();
        vectors++;
        if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o,
             core_do_o, core_spec_o, core_odd_o, core_inv_o} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0", {req0_ready_o, req1_ready_o, resp0_valid_o,
                     resp1_valid_o, resp0_err_o, resp1_err_o, core_do_o, core_spec_o, core_odd_o, core_inv_o});
        end
        vectors++;
        if ({resp0_res_o, resp1_res_o, core_s_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h want 0", resp0_res_o, resp1_res_o, core_s_o);
        end
        vectors++;
        if (core_rst_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_core_rst: got %b want 1", core_rst_o);
        end
        q0.delete(); q1.delete();
        step();
        rst = 1'b1;
        step();
        vectors++;
        if (core_rst_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_release_core_rst: got %b want 0", core_rst_o);
        end
    endtask

    task automatic test_single();
        op_t   a;
        resp_t r;
        bit    ok;
        do_reset();
        mdl_lat = 5;
        a.s = 8'h80; a.odd = 1'b0; a.inv = 1'b0; a.spec = 1'b0;
        q0.push_back(a);
        run_until(1, 50, ok);
        repeat (5) step();
        r = get_resp(0);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: got 0 want 1"); end
        vectors++; if (resp_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", resp_q.size()); end
        vectors++; if (r.port != 0) begin miscompares++; $display("FAIL single_port: got %0d want 0", r.port); end
        vectors++; if (r.res !== 8'h80 || r.err !== 1'b0) begin miscompares++; $display("FAIL single_res: got %h/%b want 80/0", r.res, r.err); end
        vectors++; if (do_cyc != ready_cyc + 1) begin miscompares++; $display("FAIL single_do_lat: got %0d want %0d", do_cyc, ready_cyc + 1); end
        vectors++; if (r.cyc != ready_cyc + 7) begin miscompares++; $display("FAIL single_resp_lat: got %0d want %0d", r.cyc, ready_cyc + 7); end
    endtask

    task automatic test_round_robin();
        op_t   o;
        resp_t r;
        bit    ok;
        do_reset();
        mdl_rand = 1'b1;
        ref_ptr = 0;
        for (int i = 0; i < 2; i++) begin
            o = rand_op(1'b0); q0.push_back(o); e0.push_back(o);
            o = rand_op(1'b0); q1.push_back(o); e1.push_back(o);
        end
        ref_arbitrate();
        run_until(4, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rr_done: got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            r = get_resp(i);
            vectors++;
            if (get_gnt(i) != i % 2 || r.port != exp_q[i].port || r.res !== exp_q[i].res || r.err !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_%0d: got gnt %0d port %0d res %h err %b want gnt %0d port %0d res %h err 0",
                         i, get_gnt(i), r.port, r.res, r.err, i % 2, exp_q[i].port, exp_q[i].res);
            end
        end
    endtask

    task automatic test_spec();
        op_t   a;
        resp_t r;
        bit    ok;
        int    d0, s0;
        do_reset();
        mdl_lat = 1;
        a = rand_op(1'b0); a.spec = 1'b1;
        d0 = do_cnt; s0 = spec_cnt;
        q1.push_back(a);
        run_until(1, 30, ok);
        repeat (3) step();
        r = get_resp(0);
        vectors++; if (!ok || resp_q.size() != 1) begin miscompares++; $display("FAIL spec_count: got %0d want 1", resp_q.size()); end
        vectors++; if (spec_cnt - s0 != 1 || do_cnt != d0) begin miscompares++; $display("FAIL spec_pulse: got spec %0d do %0d want 1 0", spec_cnt - s0, do_cnt - d0); end
        vectors++; if (r.port != 1 || r.res !== ~a.s || r.err !== 1'b0) begin miscompares++; $display("FAIL spec_res: got %0d/%h/%b want 1/%h/0", r.port, r.res, r.err, ~a.s); end
        vectors++; if (r.cyc != spec_cyc + 2) begin miscompares++; $display("FAIL spec_lat: got %0d want %0d", r.cyc, spec_cyc + 2); end
    endtask

    task automatic test_timeout();
        op_t   a, b;
        resp_t r;
        bit    ok;
        int    c0;
        do_reset();
        mdl_mute = 1'b1;
        c0 = crst_cnt;
        a = rand_op(1'b0);
        q0.push_back(a);
        run_until(1, 120, ok);
        r = get_resp(0);
        vectors++; if (!ok) begin miscompares++; $display("FAIL tmo_done: got 0 want 1"); end
        vectors++; if (r.port != 0 || r.err !== 1'b1 || r.res !== '0) begin miscompares++; $display("FAIL tmo_res: got %0d/%h/%b want 0/00/1", r.port, r.res, r.err); end
        vectors++; if (crst_cnt - c0 != 1) begin miscompares++; $display("FAIL tmo_core_rst_count: got %0d want 1", crst_cnt - c0); end
        vectors++; if (crst_cyc != do_cyc + TMO) begin miscompares++; $display("FAIL tmo_core_rst_cyc: got %0d want %0d", crst_cyc, do_cyc + TMO); end
        vectors++; if (r.cyc != crst_cyc + 1) begin miscompares++; $display("FAIL tmo_resp_cyc: got %0d want %0d", r.cyc, crst_cyc + 1); end
        mdl_mute = 1'b0; mdl_lat = 3;
        b = rand_op(1'b0);
        q0.push_back(b);
        run_until(2, 40, ok);
        r = get_resp(1);
        vectors++; if (!ok || r.port != 0 || r.res !== core_fn(b) || r.err !== 1'b0) begin miscompares++; $display("FAIL tmo_next: got %0d/%h/%b want 0/%h/0", r.port, r.res, r.err, core_fn(b)); end
        vectors++; if (crst_cnt - c0 != 1) begin miscompares++; $display("FAIL tmo_next_core_rst: got %0d want 1", crst_cnt - c0); end
    endtask

    task automatic test_coincide();
        op_t   a;
        resp_t r;
        bit    ok;
        int    c0;
        do_reset();
        mdl_lat = TMO;
        c0 = crst_cnt;
        a = rand_op(1'b0);
        q1.push_back(a);
        run_until(1, 120, ok);
        r = get_resp(0);
        vectors++; if (!ok || r.port != 1 || r.err !== 1'b0 || r.res !== core_fn(a)) begin miscompares++; $display("FAIL edge_res: got %0d/%h/%b want 1/%h/0", r.port, r.res, r.err, core_fn(a)); end
        vectors++; if (crst_cnt != c0) begin miscompares++; $display("FAIL edge_core_rst: got %0d want 0", crst_cnt - c0); end
        vectors++; if (r.cyc != do_cyc + TMO + 1) begin miscompares++; $display("FAIL edge_lat: got %0d want %0d", r.cyc, do_cyc + TMO + 1); end
    endtask

    task automatic test_reset_wait();
        op_t   a, b, c, d;
        resp_t r;
        bit    ok;
        int    d0, n0, n;
        do_reset();
        mdl_lat = 2;
        a.s = W'($urandom_range(1, 255)); a.odd = 1'b0; a.inv = 1'b0; a.spec = 1'b0;
        q0.push_back(a);
        run_until(1, 40, ok);
        step();
        mdl_mute = 1'b1;
        d0 = do_cnt;
        b = rand_op(1'b0);
        q1.push_back(b);
        n = 0;
        while (do_cnt == d0 && n < 20) begin step(); n++; end
        vectors++; if (do_cnt == d0) begin miscompares++; $display("FAIL rstw_issue: got 0 want 1"); end
        repeat (3) step();
        rst = 1'b0;
        q0.push_back(a); q1.push_back(b);
        step(); step();
        vectors++;
        if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_err_o, core_do_o, core_spec_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL rstw_ctl: got %b want 0", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, resp0_err_o, core_do_o, core_spec_o});
        end
        vectors++; if (resp0_res_o !== '0 || core_s_o !== '0) begin miscompares++; $display("FAIL rstw_data: got %h %h want 0", resp0_res_o, core_s_o); end
        vectors++; if (core_rst_o !== 1'b1) begin miscompares++; $display("FAIL rstw_core_rst: got %b want 1", core_rst_o); end
        q0.delete(); q1.delete();
        step();
        rst = 1'b1;
        mdl_mute = 1'b0;
        n0 = resp_q.size();
        man_res = W'($urandom); man_valid = 1'b1;
        step(); step();
        man_valid = 1'b0;
        repeat (8) step();
        vectors++; if (resp_q.size() != n0) begin miscompares++; $display("FAIL rstw_no_resp: got %0d want %0d", resp_q.size() - n0, 0); end
        gnt_log.delete();
        c = rand_op(1'b0); d = rand_op(1'b0);
        q0.push_back(c); q1.push_back(d);
        run_until(n0 + 2, 100, ok);
        vectors++; if (!ok || get_gnt(0) != 0 || get_gnt(1) != 1) begin miscompares++; $display("FAIL rstw_ptr: got %0d,%0d want 0,1", get_gnt(0), get_gnt(1)); end
        r = get_resp(n0);
        vectors++; if (r.port != 0 || r.res !== core_fn(c)) begin miscompares++; $display("FAIL rstw_res0: got %0d/%h want 0/%h", r.port, r.res, core_fn(c)); end
        r = get_resp(n0 + 1);
        vectors++; if (r.port != 1 || r.res !== core_fn(d)) begin miscompares++; $display("FAIL rstw_res1: got %0d/%h want 1/%h", r.port, r.res, core_fn(d)); end
    endtask

    task automatic test_random();
        op_t   o;
        resp_t r;
        bit    ok;
        int    base, n0, n1;
        do_reset();
        mdl_rand = 1'b1;
        ref_ptr = 0;
        for (int rnd = 0; rnd < 8; rnd++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            base = resp_q.size();
            for (int i = 0; i < n0; i++) begin o = rand_op(1'b1); q0.push_back(o); e0.push_back(o); end
            for (int i = 0; i < n1; i++) begin o = rand_op(1'b1); q1.push_back(o); e1.push_back(o); end
            ref_arbitrate();
            run_until(base + n0 + n1, 30 * (n0 + n1) + 20, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rand_done_%0d: got %0d want %0d", rnd, resp_q.size() - base, n0 + n1); end
            for (int i = 0; i < exp_q.size(); i++) begin
                r = get_resp(base + i);
                vectors++;
                if (r.port != exp_q[i].port || r.res !== exp_q[i].res || r.err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_%0d_%0d: got %0d/%h/%b want %0d/%h/0", rnd, i, r.port, r.res, r.err, exp_q[i].port, exp_q[i].res);
                end
                vectors++;
                if (base + i >= iss_log.size() || iss_log[base + i].s !== exp_iss[i].s || iss_log[base + i].spec !== exp_iss[i].spec) begin
                    miscompares++;
                    $display("FAIL rand_issue_%0d_%0d: got entry %0d want s %h spec %b", rnd, i, base + i, exp_iss[i].s, exp_iss[i].spec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_spec();
        test_timeout();
        test_coincide();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want completion within 100000 cycles");
        $fatal(1);
    end

endmodule
`default_nettype wire
